// File: rtl/cds_pll_pkg.sv
// Shared definitions for the CDS PLL reset/lock sequencers.
//   pll_seq_state_t : sequencer FSM state encoding (also exported on state_o)
//   PLL_*           : default timing constants derived from the 50 MHz reference
//   max3()          : helper used to size the shared timing counter
package cds_pll_pkg;

  typedef enum logic [2:0] {
    HOLD   = 3'd0,
    WAIT   = 3'd1,
    STABLE = 3'd2,
    READY  = 3'd3,
    FAULT  = 3'd4
  } pll_seq_state_t;

  localparam int unsigned PLL_REFCLK_HZ     = 50_000_000;
  localparam int unsigned PLL_RST_CYCLES    = 16;
  localparam int unsigned PLL_LOCK_TIMEOUT  = PLL_REFCLK_HZ / 1000;  // 1 ms
  localparam int unsigned PLL_STABLE_CYCLES = 1024;
  localparam int unsigned PLL_MAX_RETRY     = 3;
  localparam int unsigned PLL_LOL_W         = 8;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cds_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages to 0
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles behind d
module cds_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/cds_pll_reset_sequencer.sv
// Reset and lock-qualification sequencer for the CDS base PLL.
// Runs on the PLL reference clock only, so it keeps working while the PLL is
// unlocked or held in reset.
//   refclk     : free-running reference clock
//   rst        : asynchronous active-high reset
//   req_reset  : 1-cycle software restart request, honoured from any state
//   pll_locked : raw PLL lock, asynchronous to refclk
//   pll_rst    : PLL reset drive
//   clk_ready  : PLL output qualified as usable
//   fault      : all lock attempts exhausted
//   retry_cnt  : failed attempts in the current sequence, saturating at 3
//   lol_cnt    : loss-of-lock events since rst, saturating at all-ones
//   state_o    : current FSM state encoding
module cds_pll_reset_sequencer
  import cds_pll_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = PLL_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = PLL_STABLE_CYCLES,
  parameter int unsigned MAX_RETRY     = PLL_MAX_RETRY,
  parameter int unsigned LOL_W         = PLL_LOL_W
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             req_reset,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             clk_ready,
  output logic             fault,
  output logic [1:0]       retry_cnt,
  output logic [LOL_W-1:0] lol_cnt,
  output logic [2:0]       state_o
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int AW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [AW-1:0] RETRY_LIMIT = AW'(MAX_RETRY);

  logic lk_s;

  cds_sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk_s)
  );

  pll_seq_state_t   state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Full-width attempt count so MAX_RETRY is honoured even above the 2-bit readout.
  logic [AW-1:0]    attempt_q, attempt_d;
  logic [AW-1:0]    attempt_inc;
  logic [LOL_W-1:0] lol_q, lol_d;
  logic             pll_rst_q, pll_rst_d;
  logic             clk_ready_q, clk_ready_d;
  logic             fault_q, fault_d;
  logic [1:0]       retry_cnt_q, retry_cnt_d;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      attempt_q   <= '0;
      lol_q       <= '0;
      pll_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
      retry_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      attempt_q   <= attempt_d;
      lol_q       <= lol_d;
      pll_rst_q   <= pll_rst_d;
      clk_ready_q <= clk_ready_d;
      fault_q     <= fault_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    attempt_d   = attempt_q;
    lol_d       = lol_q;
    attempt_inc = attempt_q + AW'(1);

    if (req_reset) begin
      // Software restart beats every other transition and is never a loss of lock.
      state_d   = HOLD;
      attempt_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == RST_LAST) state_d = WAIT;
          else                   cnt_d   = cnt_q + CW'(1);
        end
        WAIT: begin
          // Lock is tested before the timeout, so a late lock still counts.
          if (lk_s) begin
            state_d = STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            attempt_d = attempt_inc;
            state_d   = (attempt_inc == RETRY_LIMIT) ? FAULT : HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STABLE: begin
          // A drop before qualification is just a restart of the wait, not a loss of lock.
          if (!lk_s)                    state_d = WAIT;
          else if (cnt_q == STABLE_LAST) state_d = READY;
          else                          cnt_d   = cnt_q + CW'(1);
        end
        READY: begin
          if (!lk_s) begin
            state_d   = HOLD;
            attempt_d = '0;
            if (lol_q != '1) lol_d = lol_q + LOL_W'(1);
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end

    // Every state entry (including a req_reset restart of HOLD) starts timing from zero.
    if ((state_d != state_q) || req_reset) cnt_d = '0;

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    pll_rst_d   = (state_d == HOLD) || (state_d == FAULT);
    clk_ready_d = (state_d == READY);
    fault_d     = (state_d == FAULT);
    retry_cnt_d = (32'(attempt_d) >= 32'd3) ? 2'd3 : 2'(attempt_d);
  end

  assign pll_rst   = pll_rst_q;
  assign clk_ready = clk_ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_cnt_q;
  assign lol_cnt   = lol_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_cds_pll_reset_sequencer.sv
module tb_cds_pll_reset_sequencer;

  localparam logic [2:0] S_HOLD   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_READY  = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_reset = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, clk_ready, fault;
  logic [1:0] retry_cnt;
  logic [7:0] lol_cnt;
  logic [2:0] state_o;

  logic       req2 = 1'b0;
  logic       lock2 = 1'b0;
  logic       pll_rst2, clk_ready2, fault2;
  logic [1:0] retry2;
  logic [7:0] lol2;
  logic [2:0] state2;

  int errors = 0;
  int checks = 0;
  int inv_prints = 0;

  always #5 clk = ~clk;

  cds_pll_reset_sequencer #(
    .RST_CYCLES(16), .LOCK_TIMEOUT(100), .STABLE_CYCLES(1024), .MAX_RETRY(3), .LOL_W(8)
  ) dut (
    .refclk(clk), .rst(rst), .req_reset(req_reset), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .clk_ready(clk_ready), .fault(fault),
    .retry_cnt(retry_cnt), .lol_cnt(lol_cnt), .state_o(state_o)
  );

  // Short-timing instance used for the 256-event loss-of-lock saturation run.
  cds_pll_reset_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRY(3), .LOL_W(8)
  ) dut_fast (
    .refclk(clk), .rst(rst), .req_reset(req2), .pll_locked(lock2),
    .pll_rst(pll_rst2), .clk_ready(clk_ready2), .fault(fault2),
    .retry_cnt(retry2), .lol_cnt(lol2), .state_o(state2)
  );

  typedef struct {
    logic       req;
    logic       lock;
    int         n;
    logic [2:0] st;
    logic       prst;
    logic       rdy;
    logic       flt;
    logic [1:0] rc;
    logic [7:0] lol;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'(S_HOLD));
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_clk_ready"}, 32'(clk_ready), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
    chk({tag, "_lol"}, 32'(lol_cnt), 32'd0);
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
    int n = 0;
    while (state_o !== tgt && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(state_o), 32'(tgt));
  endtask

  // Safety properties, checked every cycle on both instances.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((clk_ready && pll_rst) || (clk_ready && fault) ||
          (clk_ready2 && pll_rst2) || (clk_ready2 && fault2)) begin
        errors++;
        if (inv_prints < 10) begin
          inv_prints++;
          $display("FAIL invariant: rdy=%0b prst=%0b flt=%0b rdy2=%0b prst2=%0b flt2=%0b required no overlap",
                   clk_ready, pll_rst, fault, clk_ready2, pll_rst2, fault2);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    int lol_exp;

    // Timeout/fault/restart sequence, then lock qualification; edge counts from rst release.
    //           req lock  n     state     prst rdy flt rc lol
    vecs[0]  = '{0, 0, 14,   S_HOLD,   1, 0, 0, 2'd0, 8'd0};  // edge 15
    vecs[1]  = '{0, 0, 1,    S_WAIT,   0, 0, 0, 2'd0, 8'd0};  // edge 16
    vecs[2]  = '{0, 0, 99,   S_WAIT,   0, 0, 0, 2'd0, 8'd0};  // edge 115
    vecs[3]  = '{0, 0, 1,    S_HOLD,   1, 0, 0, 2'd1, 8'd0};  // edge 116 timeout 1
    vecs[4]  = '{0, 0, 16,   S_WAIT,   0, 0, 0, 2'd1, 8'd0};  // edge 132
    vecs[5]  = '{0, 0, 100,  S_HOLD,   1, 0, 0, 2'd2, 8'd0};  // edge 232 timeout 2
    vecs[6]  = '{0, 0, 116,  S_FAULT,  1, 0, 1, 2'd3, 8'd0};  // edge 348 timeout 3
    vecs[7]  = '{0, 0, 50,   S_FAULT,  1, 0, 1, 2'd3, 8'd0};  // edge 398 fault sticks
    vecs[8]  = '{1, 0, 1,    S_HOLD,   1, 0, 0, 2'd0, 8'd0};  // edge 399 req_reset
    vecs[9]  = '{0, 1, 16,   S_WAIT,   0, 0, 0, 2'd0, 8'd0};  // edge 415
    vecs[10] = '{0, 1, 1,    S_STABLE, 0, 0, 0, 2'd0, 8'd0};  // edge 416
    vecs[11] = '{0, 1, 1023, S_STABLE, 0, 0, 0, 2'd0, 8'd0};  // edge 1439
    vecs[12] = '{0, 1, 1,    S_READY,  0, 1, 0, 2'd0, 8'd0};  // edge 1440
    vecs[13] = '{0, 1, 100,  S_READY,  0, 1, 0, 2'd0, 8'd0};  // edge 1540

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    $display("reset: state=%0d pll_rst=%0b clk_ready=%0b", state_o, pll_rst, clk_ready);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req_reset  = vecs[i].req;
      pll_locked = vecs[i].lock;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      $display("row %0d: state=%0d pll_rst=%0b clk_ready=%0b fault=%0b retry=%0d lol=%0d",
               i, state_o, pll_rst, clk_ready, fault, retry_cnt, lol_cnt);
      chk($sformatf("row%0d_state", i), 32'(state_o), 32'(vecs[i].st));
      chk($sformatf("row%0d_pll_rst", i), 32'(pll_rst), 32'(vecs[i].prst));
      chk($sformatf("row%0d_clk_ready", i), 32'(clk_ready), 32'(vecs[i].rdy));
      chk($sformatf("row%0d_fault", i), 32'(fault), 32'(vecs[i].flt));
      chk($sformatf("row%0d_retry", i), 32'(retry_cnt), 32'(vecs[i].rc));
      chk($sformatf("row%0d_lol", i), 32'(lol_cnt), 32'(vecs[i].lol));
    end

    // One-cycle lock drop in READY.
    @(negedge clk); pll_locked = 1'b0;
    @(negedge clk); pll_locked = 1'b1;
    n = 0;
    while (clk_ready && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    $display("lol drop: clk_ready=%0b state=%0d lol=%0d after %0d edges", clk_ready, state_o, lol_cnt, n);
    chk("lol_drop_ready", 32'(clk_ready), 32'd0);
    chk("lol_drop_count", 32'(lol_cnt), 32'd1);
    chk("lol_drop_state", 32'(state_o), 32'(S_HOLD));
    chk("lol_drop_pll_rst", 32'(pll_rst), 32'd1);
    chk("lol_drop_retry", 32'(retry_cnt), 32'd0);

    // Glitch at STABLE cycle 500: back to WAIT, no loss-of-lock count, fresh window.
    wait_state(S_STABLE, 100, "glitch_reach_stable");
    repeat (499) @(posedge clk);
    #1;
    chk("glitch_pre_state", 32'(state_o), 32'(S_STABLE));
    @(negedge clk); pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    wait_state(S_WAIT, 10, "glitch_to_wait");
    chk("glitch_lol", 32'(lol_cnt), 32'd1);
    chk("glitch_ready", 32'(clk_ready), 32'd0);
    wait_state(S_STABLE, 10, "glitch_restable");
    m = 0;
    while (!clk_ready && m < 1100) begin
      @(posedge clk); #1;
      m++;
    end
    $display("glitch: stable window to clk_ready = %0d edges", m);
    chk("glitch_window", 32'(m), 32'd1024);
    chk("glitch_ready_state", 32'(state_o), 32'(S_READY));
    chk("glitch_lol_after", 32'(lol_cnt), 32'd1);

    // req_reset in the cycle the FSM sees the lock drop: restart wins, no count.
    @(negedge clk); pll_locked = 1'b0;
    @(negedge clk);
    @(negedge clk); req_reset = 1'b1;
    @(posedge clk); #1;
    $display("req+drop: state=%0d lol=%0d clk_ready=%0b", state_o, lol_cnt, clk_ready);
    chk("reqdrop_state", 32'(state_o), 32'(S_HOLD));
    chk("reqdrop_lol", 32'(lol_cnt), 32'd1);
    chk("reqdrop_ready", 32'(clk_ready), 32'd0);
    @(negedge clk); req_reset = 1'b0; pll_locked = 1'b1;

    // Async reset in WAIT.
    @(negedge clk); pll_locked = 1'b0;
    wait_state(S_WAIT, 40, "rst_reach_wait");
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    $display("rst in WAIT: state=%0d pll_rst=%0b lol=%0d", state_o, pll_rst, lol_cnt);
    chk_reset_vals("rst_wait");

    // Restart with lock tied high: pll_rst for 16 edges, clk_ready 1025 edges later.
    pll_locked = 1'b1;
    @(negedge clk); rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (pll_rst && n < 40);
    chk("seq_rst_len", 32'(n), 32'd16);
    chk("seq_retry", 32'(retry_cnt), 32'd0);
    m = 0;
    while (!clk_ready && m < 1200) begin
      @(posedge clk); #1;
      m++;
    end
    $display("restart: pll_rst held %0d edges, clk_ready %0d edges after release of pll_rst", n, m);
    chk("seq_ready_delay", 32'(m), 32'd1025);

    // Async reset in READY.
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    $display("rst in READY: state=%0d clk_ready=%0b pll_rst=%0b", state_o, clk_ready, pll_rst);
    chk_reset_vals("rst_ready");
    @(negedge clk); rst = 1'b0;

    // Loss-of-lock saturation on the short-timing instance.
    @(negedge clk); lock2 = 1'b1; req2 = 1'b1;
    @(negedge clk); req2 = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      n = 0;
      while (!clk_ready2 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("sat%0d_ready", i), 32'(clk_ready2), 32'd1);
      @(negedge clk); lock2 = 1'b0;
      @(negedge clk); lock2 = 1'b1;
      n = 0;
      while (clk_ready2 && n < 5) begin
        @(posedge clk); #1;
        n++;
      end
      lol_exp = (i > 255) ? 255 : i;
      $display("sat %0d: lol=%0d state=%0d", i, lol2, state2);
      chk($sformatf("sat%0d_lol", i), 32'(lol2), 32'(lol_exp));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
